// File: rtl/pdm_out_multi.sv
// pdm_out_multi: N-channel delta-sigma PDM output stage fed by double-buffered signed PCM frames.
// Build option PDM_SECOND_ORDER_EN swaps the first-order accumulator for a second-order modulator.
module pdm_out_multi #(
    parameter int NUM_CH = 2,
    parameter int DATA_W = 14,
    parameter int DIV_W  = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NUM_CH*DATA_W-1:0] sample_i,
    input  logic                     valid_i,
    output logic                     ready_o,
    input  logic [DIV_W-1:0]         div_i,
    input  logic [NUM_CH-1:0]        mute_i,
    output logic [NUM_CH-1:0]        pdm_o,
    output logic                     tick_o
);
    // Handshake: a frame transfers on any rising clk_i with valid_i && ready_o high;
    // ready_o is a function of the pending-buffer flag only and never looks at valid_i.

    logic [DIV_W-1:0]         cnt;
    logic                     tick;
    logic                     accept;
    logic                     pending_full;
    logic [NUM_CH*DATA_W-1:0] pending;
    logic [NUM_CH*DATA_W-1:0] active;
    logic [NUM_CH*DATA_W-1:0] src;

    // ">=" rather than "==" so lowering div_i below cnt ticks at once instead of wrapping.
    assign tick    = (cnt >= div_i);
    assign ready_o = ~pending_full;
    assign accept  = valid_i && ready_o;
    // A pending frame becomes active on this tick's edge, so the modulator already uses it here.
    assign src     = pending_full ? pending : active;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt    <= '0;
            tick_o <= 1'b0;
        end else begin
            cnt    <= tick ? '0 : cnt + 1'b1;
            tick_o <= tick;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pending      <= '0;
            active       <= '0;
            pending_full <= 1'b0;
        end else if (tick && pending_full) begin
            active       <= pending;
            pending_full <= 1'b0;
        end else if (accept) begin
            pending      <= sample_i;
            pending_full <= 1'b1;
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic signed [DATA_W-1:0] x;
        logic                     bit_q;

        assign x        = src[k*DATA_W +: DATA_W];
        assign pdm_o[k] = bit_q;

`ifdef PDM_SECOND_ORDER_EN
        localparam int IW = DATA_W + 4;
        localparam int SW = DATA_W + 6;
        localparam logic signed [SW-1:0] I_MAX = {{(SW-IW+1){1'b0}}, {(IW-1){1'b1}}};
        localparam logic signed [SW-1:0] I_MIN = {{(SW-IW+1){1'b1}}, {(IW-1){1'b0}}};
        localparam logic signed [SW-1:0] FS    = {{(SW-DATA_W){1'b0}}, 1'b1, {(DATA_W-1){1'b0}}};

        logic signed [IW-1:0] i1;
        logic signed [IW-1:0] i2;
        logic                 y;
        logic signed [SW-1:0] xw;
        logic signed [SW-1:0] fb;
        logic signed [SW-1:0] i1w;
        logic signed [SW-1:0] i2w;
        logic signed [SW-1:0] s1;
        logic signed [SW-1:0] s2;

        function automatic logic signed [IW-1:0] sat(input logic signed [SW-1:0] v);
            if (v > I_MAX) begin
                return I_MAX[IW-1:0];
            end else if (v < I_MIN) begin
                return I_MIN[IW-1:0];
            end
            return v[IW-1:0];
        endfunction

        assign y   = ~i2[IW-1];
        assign xw  = mute_i[k] ? '0 : {{(SW-DATA_W){x[DATA_W-1]}}, x};
        assign fb  = y ? FS : -FS;
        assign i1w = {{(SW-IW){i1[IW-1]}}, i1};
        assign i2w = {{(SW-IW){i2[IW-1]}}, i2};
        // Both sums use the integrator values from before this tick.
        assign s1  = i1w + xw - fb;
        assign s2  = i2w + i1w + xw - (fb <<< 1);

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                i1    <= '0;
                i2    <= '0;
                bit_q <= 1'b0;
            end else if (tick) begin
                i1    <= sat(s1);
                i2    <= sat(s2);
                bit_q <= y;
            end
        end
`else
        logic [DATA_W-1:0] acc;
        logic [DATA_W-1:0] u;
        logic [DATA_W:0]   sum;

        // Offset binary: flipping the sign bit maps -2^(W-1)..2^(W-1)-1 onto 0..2^W-1.
        assign u   = mute_i[k] ? {1'b1, {(DATA_W-1){1'b0}}} : {~x[DATA_W-1], x[DATA_W-2:0]};
        assign sum = {1'b0, acc} + {1'b0, u};

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                acc   <= '0;
                bit_q <= 1'b0;
            end else if (tick) begin
                acc   <= sum[DATA_W-1:0];
                bit_q <= sum[DATA_W];
            end
        end
`endif
    end
endmodule

// File: tb/tb_pdm_out_multi.sv
// Directed bench for pdm_out_multi: reset, tick divider, density, mute and frame handshake.
// Second-order density checks compile in when PDM_SECOND_ORDER_EN is defined.
module tb_pdm_out_multi;
    localparam int NUM_CH = 2;
    localparam int DATA_W = 14;
    localparam int DIV_W  = 8;
    localparam int FW     = NUM_CH * DATA_W;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b1;
    logic [FW-1:0]     sample_i;
    logic              valid_i;
    logic              ready_o;
    logic [DIV_W-1:0]  div_i;
    logic [NUM_CH-1:0] mute_i;
    logic [NUM_CH-1:0] pdm_o;
    logic              tick_o;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_q[$];

    pdm_out_multi #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .DIV_W(DIV_W)) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .sample_i (sample_i),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .div_i    (div_i),
        .mute_i   (mute_i),
        .pdm_o    (pdm_o),
        .tick_o   (tick_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [FW-1:0] mk(input int c0, input int c1);
        logic [FW-1:0] f;
        f = '0;
        f[DATA_W-1:0]        = c0[DATA_W-1:0];
        f[2*DATA_W-1:DATA_W] = c1[DATA_W-1:0];
        return f;
    endfunction

    task automatic wait_tick(input int bound, output int cyc);
        cyc = 0;
        for (int i = 1; i <= bound; i++) begin
            @(negedge clk_i);
            if (tick_o) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic do_reset(input logic [DIV_W-1:0] div);
        @(negedge clk_i);
        rst_i    = 1'b1;
        valid_i  = 1'b0;
        sample_i = '0;
        mute_i   = '0;
        div_i    = div;
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    // Frame is accepted before the first tick, so both accumulators start from zero on it.
    task automatic start_frame(input logic [FW-1:0] frame);
        do_reset(1);
        sample_i = frame;
        valid_i  = 1'b1;
        @(negedge clk_i);
        check("load_ready_low", ready_o, 0);
        valid_i = 1'b0;
        div_i   = 0;
    endtask

    task automatic count_ticks(input int n, input bit alt, output int o0, output int o1);
        int got;
        got = 0;
        o0  = 0;
        o1  = 0;
        for (int c = 0; c < 2 * n + 20 && got < n; c++) begin
            @(negedge clk_i);
            if (tick_o) begin
                if (alt && got < 16) check("ch0_alternate", pdm_o[0], got % 2);
                o0 += pdm_o[0];
                o1 += pdm_o[1];
                got++;
            end
        end
        check("tick_budget", got, n);
    endtask

    initial begin
        int cyc;
        int o0;
        int o1;
        int low_cnt;

        valid_i  = 1'b0;
        sample_i = '0;
        div_i    = 3;
        mute_i   = '0;

        // Reset values and divider.
        @(negedge clk_i);
        check("rst_pdm", pdm_o, 0);
        check("rst_tick", tick_o, 0);
        check("rst_ready", ready_o, 1);
        @(negedge clk_i);
        rst_i = 1'b0;
        wait_tick(50, cyc);
        check("first_tick_cycle", cyc, 4);
        wait_tick(50, cyc);
        check("tick_period_div3", cyc, 4);
        @(negedge clk_i);
        check("no_tick_cnt1", tick_o, 0);
        @(negedge clk_i);
        check("no_tick_cnt2", tick_o, 0);
        div_i = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            check("tick_every_cycle", tick_o, 1);
        end

        // Accept coinciding with a tick lands in pending only; then reset mid-cycle.
        sample_i = mk(-8192, -8192);
        valid_i  = 1'b1;
        @(negedge clk_i);
        valid_i = 1'b0;
        check("accept_on_tick_pending", ready_o, 0);
        @(posedge clk_i);
        #2;
        rst_i = 1'b1;
        #1;
        check("async_rst_pdm", pdm_o, 0);
        check("async_rst_tick", tick_o, 0);
        check("async_rst_ready", ready_o, 1);

`ifndef PDM_SECOND_ORDER_EN
        start_frame(mk(0, 4096));
        exp_q.push_back(16'd512);
        exp_q.push_back(16'd768);
        count_ticks(1024, 1'b1, o0, o1);
        check("density_ch0_zero", o0, exp_q.pop_front());
        check("density_ch1_4096", o1, exp_q.pop_front());

        start_frame(mk(-8192, 8191));
        exp_q.push_back(16'd0);
        exp_q.push_back(16'd1023);
        count_ticks(1024, 1'b0, o0, o1);
        check("density_ch0_min", o0, exp_q.pop_front());
        check("density_ch1_max", o1, exp_q.pop_front());

        mute_i = 2'b10;
        exp_q.push_back(16'd0);
        exp_q.push_back(16'd512);
        count_ticks(1024, 1'b0, o0, o1);
        check("mute_ch0_min", o0, exp_q.pop_front());
        check("mute_ch1_half", o1, exp_q.pop_front());
`else
        start_frame(mk(4096, 0));
        count_ticks(4096, 1'b0, o0, o1);
        check("so_ch0_4096", (o0 >= 3068 && o0 <= 3076), 1);
        check("so_ch1_zero", (o1 >= 2044 && o1 <= 2052), 1);
        mute_i = 2'b01;
        count_ticks(4096, 1'b0, o0, o1);
        check("so_ch0_muted", (o0 >= 2044 && o0 <= 2052), 1);
`endif

        // Two back-to-back frames with valid_i held, div_i=9.
        do_reset(9);
        sample_i = mk(8191, 8191);
        valid_i  = 1'b1;
        exp_q.push_back(16'h0);
        exp_q.push_back(16'h2);
        exp_q.push_back(16'h0);
        @(posedge clk_i);
        #1;
        check("hs_first_accepted", ready_o, 0);
        sample_i = mk(-8192, 0);
        low_cnt  = 0;
        for (int k = 0; k < 30; k++) begin
            if (ready_o) break;
            low_cnt++;
            @(posedge clk_i);
            #1;
        end
        check("hs_ready_low_cycles", low_cnt, 9);
        check("hs_tick_frees_buffer", tick_o, 1);
`ifndef PDM_SECOND_ORDER_EN
        check("hs_pdm_frame_a", pdm_o, exp_q.pop_front());
`endif
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
        check("hs_second_accepted", ready_o, 0);
        wait_tick(20, cyc);
        check("hs_tick_spacing_a", cyc, 10);
`ifndef PDM_SECOND_ORDER_EN
        check("hs_pdm_frame_b", pdm_o, exp_q.pop_front());
`endif
        check("hs_ready_after_b", ready_o, 1);
        wait_tick(20, cyc);
        check("hs_tick_spacing_b", cyc, 10);
`ifndef PDM_SECOND_ORDER_EN
        check("hs_pdm_frame_b2", pdm_o, exp_q.pop_front());
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
